// File: rtl/n_bin_avg_wrapper.sv
// Per-bin running average of framed FFT spectra over 2^k spectra.
// Build option AVG_ROUND_EN: round-half-up before the final shift.
module n_bin_avg_wrapper #(
  parameter int N         = 16,
  parameter int N_out     = 8,
  parameter int SUM_WIDTH = 32,
  parameter int BINS      = 4
) (
  input  logic                                  clk,
  input  logic                                  arest_n,
  input  logic                                  fft_ready,
  input  logic signed [N-1:0]                   in_data,
  input  logic [7:0]                            N_AVGS_in,
  output logic                                  valid,
  output logic [BINS*N/N_out-1:0][N_out-1:0]    out_data
);

  localparam int BW = $clog2(BINS);
  localparam logic [BW-1:0] LAST = BW'(BINS - 1);

  logic                        cap;
  logic [BW-1:0]               bin_cnt;
  logic [7:0]                  spec_cnt;
  logic [2:0]                  k;
  logic [2:0]                  k_in;
  logic signed [SUM_WIDTH-1:0] acc [BINS];
  logic signed [SUM_WIDTH-1:0] fin [BINS];
  logic signed [SUM_WIDTH-1:0] ext;
  logic signed [SUM_WIDTH-1:0] rnd;
  logic [BINS*N-1:0]           avg_flat;
  logic                        last_bin;
  logic                        start;
  logic                        mid;
  logic                        wrap;
  logic                        done;

  assign ext = {{(SUM_WIDTH-N){in_data[N-1]}}, in_data};

  // Highest set bit wins, so 0 maps to k=0 and non-powers round down.
  always_comb begin
    k_in = '0;
    for (int i = 0; i < 8; i++)
      if (N_AVGS_in[i]) k_in = 3'(i);
  end

`ifdef AVG_ROUND_EN
  assign rnd = (k == 3'd0) ? '0 :
               (SUM_WIDTH'(1) << (k - 3'd1));
`else
  assign rnd = '0;
`endif

  assign last_bin = cap && (bin_cnt == LAST);
  assign start    = !cap && fft_ready;
  assign mid      = cap && !last_bin;
  assign done     = last_bin &&
                    ((spec_cnt + 8'd1) == (8'd1 << k));
  assign wrap     = last_bin && !done;

  // The last bin is still in flight on the completion edge.
  always_comb begin
    avg_flat = '0;
    for (int b = 0; b < BINS; b++) begin
      fin[b] = acc[b] + rnd;
      if (b == BINS - 1) fin[b] = fin[b] + ext;
      avg_flat[b*N +: N] = N'(fin[b] >>> k);
    end
  end

  always_ff @(posedge clk) begin
    if (arest_n) begin
      cap      <= 1'b0;
      bin_cnt  <= '0;
      spec_cnt <= '0;
      k        <= '0;
      valid    <= 1'b0;
      out_data <= '0;
      for (int b = 0; b < BINS; b++) acc[b] <= '0;
    end else begin
      valid <= 1'b0;
      unique case (1'b1)
        start: begin
          acc[0]  <= acc[0] + ext;
          cap     <= 1'b1;
          bin_cnt <= BW'(1);
          if (spec_cnt == 8'd0) k <= k_in;
        end
        mid: begin
          acc[bin_cnt] <= acc[bin_cnt] + ext;
          bin_cnt      <= bin_cnt + BW'(1);
        end
        wrap: begin
          acc[LAST] <= acc[LAST] + ext;
          cap       <= 1'b0;
          bin_cnt   <= '0;
          spec_cnt  <= spec_cnt + 8'd1;
        end
        done: begin
          for (int b = 0; b < BINS; b++) acc[b] <= '0;
          cap      <= 1'b0;
          bin_cnt  <= '0;
          spec_cnt <= '0;
          valid    <= 1'b1;
          out_data <= avg_flat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n_bin_avg_wrapper.sv
// Randomized bench for n_bin_avg_wrapper against a per-bin sum model.
// Define AVG_ROUND_EN for both RTL and bench to check the rounding build.
module tb_n_bin_avg_wrapper;

  localparam int N    = 16;
  localparam int NO   = 8;
  localparam int SW   = 32;
  localparam int BINS = 4;
  localparam int W    = BINS * N / NO;

  typedef logic [BINS-1:0][N-1:0] spec_t;

  logic                    clk = 1'b0;
  logic                    arest_n = 1'b1;
  logic                    fft_ready = 1'b0;
  logic signed [N-1:0]     in_data = '0;
  logic [7:0]              navg = 8'd1;
  logic                    valid;
  logic [W-1:0][NO-1:0]    out_data;

  n_bin_avg_wrapper #(
    .N(N), .N_out(NO), .SUM_WIDTH(SW), .BINS(BINS)
  ) dut (
    .clk(clk), .arest_n(arest_n), .fft_ready(fft_ready),
    .in_data(in_data), .N_AVGS_in(navg),
    .valid(valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nexp = 0;
  int sum [BINS];
  int cnt = 0;
  int div = 1;
  bit mon_en = 1'b0;
  logic [63:0] exp_q [$];
  logic [63:0] model_out = '0;
  logic [63:0] last_out = '0;

  localparam spec_t SA = {16'hdc44, 16'h2392, 16'h9a7b, 16'h5af7};
  localparam spec_t SB = {16'hff2f, 16'h5c85, 16'h0b79, 16'h6bb0};
`ifdef AVG_ROUND_EN
  localparam logic [63:0] EXP2 = 64'hedba400cd2fa6354;
`else
  localparam logic [63:0] EXP2 = 64'hedb9400bd2fa6353;
`endif

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int eff_div(input logic [7:0] n);
    int d = 1;
    while (d * 2 <= int'(n)) d = d * 2;
    return d;
  endfunction

  function automatic logic [N-1:0] avg1(input int s, input int d);
    int q;
`ifdef AVG_ROUND_EN
    if (d > 1) s = s + d / 2;
`endif
    if (s >= 0) q = s / d;
    else q = -((-s + d - 1) / d);
    return q[N-1:0];
  endfunction

  task automatic model_spec(input spec_t s, input logic [7:0] n0);
    logic [63:0] e;
    if (cnt == 0) div = eff_div(n0);
    for (int b = 0; b < BINS; b++) sum[b] += int'($signed(s[b]));
    cnt++;
    if (cnt == div) begin
      e = '0;
      for (int b = 0; b < BINS; b++) e[b*N +: N] = avg1(sum[b], div);
      exp_q.push_back(e);
      nexp++;
      cnt = 0;
      for (int b = 0; b < BINS; b++) sum[b] = 0;
    end
  endtask

  task automatic send(input spec_t s, input int gap, input bit glitch);
    logic [7:0] n0;
    n0 = navg;
    for (int b = 0; b < BINS; b++) begin
      fft_ready = (b == 0) || (glitch && b == 2);
      in_data = s[b];
      @(posedge clk); #1;
    end
    fft_ready = 1'b0;
    model_spec(s, n0);
    repeat (gap) begin
      in_data = N'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_partial(input spec_t s, input int nb);
    for (int b = 0; b < nb; b++) begin
      fft_ready = (b == 0);
      in_data = s[b];
      @(posedge clk); #1;
    end
    fft_ready = 1'b0;
  endtask

  task automatic do_reset();
    arest_n = 1'b1;
    fft_ready = 1'b0;
    @(posedge clk); #1;
    arest_n = 1'b0;
    cnt = 0;
    for (int b = 0; b < BINS; b++) sum[b] = 0;
    model_out = '0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        nvalid++;
        last_out = out_data;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          model_out = exp_q.pop_front();
          check("avg", out_data, model_out);
        end
      end else begin
        if (exp_q.size() != 0) begin
          check("missing_valid", 64'd0, 64'd1);
          model_out = exp_q.pop_front();
        end
        check("hold", out_data, model_out);
      end
    end
  end

  initial begin
    spec_t s;
    int v0;
    for (int b = 0; b < BINS; b++) sum[b] = 0;
    repeat (2) @(posedge clk);
    #1;
    arest_n = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_out", out_data, 64'd0);
    repeat (50) @(posedge clk);
    #1;
    check("idle_nvalid", 64'(nvalid), 64'd0);

    navg = 8'd1;
    send(SA, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pass_flat", last_out, 64'hdc4423929a7b5af7);
    check("pass_word0", 64'(last_out[7:0]), 64'hf7);

    navg = 8'd2;
    v0 = nvalid;
    send(SA, 1, 1'b0);
    send(SB, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("avg2_flat", last_out, EXP2);
    check("avg2_count", 64'(nvalid - v0), 64'd1);

    v0 = nvalid;
    send(SA, 1, 1'b0);
    send(SB, 1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("glitch_flat", last_out, EXP2);
    check("glitch_count", 64'(nvalid - v0), 64'd1);

    navg = 8'd4;
    v0 = nvalid;
    repeat (8) begin
      for (int b = 0; b < BINS; b++) s[b] = N'($urandom);
      send(s, 0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("avg4_count", 64'(nvalid - v0), 64'd2);

    navg = 8'd2;
    v0 = nvalid;
    send(SA, 0, 1'b0);
    send_partial(SB, 2);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_count", 64'(nvalid - v0), 64'd0);
    send(SA, 1, 1'b0);
    send(SB, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_count2", 64'(nvalid - v0), 64'd1);
    check("rst_mid_flat", last_out, EXP2);

    do_reset();
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) navg = 8'($urandom_range(0, 9));
      for (int b = 0; b < BINS; b++) begin
        case ($urandom_range(0, 5))
          0: s[b] = 16'h8000;
          1: s[b] = 16'h7fff;
          default: s[b] = N'($urandom);
        endcase
      end
      send(s, $urandom_range(0, 3), $urandom_range(0, 4) == 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    check("nvalid_total", 64'(nvalid), 64'(nexp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
